// File: rtl/mem_pkg.sv
// Shared types and sizing for the byte-wide memory master.
package mem_pkg;

  localparam int MEM_ADDR_W     = 16;
  localparam int MEM_DATA_W     = 8;
  localparam int MEM_RD_LATENCY = 1;
  localparam int RSP_DATA_W     = 2 * MEM_DATA_W;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LO   = 3'd1,
    HI   = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } mem_state_t;

endpackage

// File: rtl/mem_master.sv
// Splits 8/16-bit core accesses into byte cycles on a synchronous-read memory.
//
// state | meaning
// IDLE  | ready for a request, strobes low
// LO    | low byte presented at addr
// HI    | high byte presented at addr+1 (wide only)
// WAIT  | read data from the last presented byte arrives
// DONE  | rsp_valid pulse, rsp_rdata valid
module mem_master
  import mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic                  req_wide,
  input  logic [MEM_ADDR_W-1:0] req_addr,
  input  logic [RSP_DATA_W-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [RSP_DATA_W-1:0] rsp_rdata,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [MEM_DATA_W-1:0] mem_wdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  input  logic [MEM_DATA_W-1:0] mem_rdata
);

  mem_state_t            state_q, state_d;
  logic [MEM_ADDR_W-1:0] addr_q;
  logic                  we_q, wide_q;
  logic [RSP_DATA_W-1:0] wdata_q;
  logic [MEM_DATA_W-1:0] lo_q;

  logic [MEM_ADDR_W-1:0] mem_addr_d;
  logic [MEM_DATA_W-1:0] mem_wdata_d;
  logic                  mem_rd_d, mem_wr_d;
  logic                  rsp_valid_d;
  logic [RSP_DATA_W-1:0] rsp_rdata_d;
  logic                  accept;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;

  // Memory-side outputs are registered from the next state so they line up
  // with the state they belong to and hold their value between accesses.
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = LO;
          mem_addr_d  = req_addr;
          mem_wdata_d = req_wdata[MEM_DATA_W-1:0];
          mem_rd_d    = !req_we;
          mem_wr_d    = req_we;
        end
      end
      LO: begin
        if (wide_q) begin
          state_d     = HI;
          mem_addr_d  = addr_q + MEM_ADDR_W'(1);
          mem_wdata_d = wdata_q[RSP_DATA_W-1:MEM_DATA_W];
          mem_rd_d    = !we_q;
          mem_wr_d    = we_q;
        end else if (we_q) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          state_d = WAIT;
        end
      end
      HI: begin
        if (we_q) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        state_d     = DONE;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = wide_q ? {mem_rdata, lo_q} : {{MEM_DATA_W{1'b0}}, mem_rdata};
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wide_q    <= 1'b0;
      wdata_q   <= '0;
      lo_q      <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_rd    <= mem_rd_d;
      mem_wr    <= mem_wr_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      if (accept) begin
        addr_q  <= req_addr;
        we_q    <= req_we;
        wide_q  <= req_wide;
        wdata_q <= req_wdata;
      end
      // Low byte of a wide read lands while HI is presenting the high address.
      if (state_q == HI && !we_q)
        lo_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_master.sv
// Directed bench: mem_master driving a 64 KiB synchronous-read byte memory.
module tb_mem_master;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_wide;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem_arr [0:65535];

  int nchecks = 0;
  int nerr    = 0;

  int          lat;
  logic [15:0] rd;
  logic [7:0]  saved_byte;
  int          got;
  logic [15:0] b2b_addr [3] = '{16'h1234, 16'h0100, 16'h0101};
  logic [15:0] b2b_exp  [3] = '{16'h00A5, 16'h00EF, 16'h00BE};

  mem_master dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_wide  (req_wide),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read byte memory, one cycle read latency.
  always @(posedge clk) begin
    if (mem_wr) mem_arr[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem_arr[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) check("strobe_exclusive", {31'd0, mem_rd && mem_wr}, 32'd0);

  // Issues one request; lat is the edge (relative to accept edge T) at which
  // rsp_valid is sampled high, 0 if it never came.
  task automatic do_req(input logic we, input logic wide, input logic [15:0] addr,
                        input logic [15:0] wdata, output int lat_o, output logic [15:0] rdata_o);
    int guard;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_wide  = wide;
    req_addr  = addr;
    req_wdata = wdata;
    guard = 0;
    while (!req_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check("accept_timeout", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    lat_o   = 0;
    rdata_o = 16'hDEAD;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) req_valid = 1'b0;
      if (rsp_valid) begin
        lat_o   = k + 1;
        rdata_o = rsp_rdata;
        break;
      end
    end
    @(negedge clk);
    check("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_wide  = 1'b0;
    req_addr  = 16'h0;
    req_wdata = 16'h0;
    repeat (2) @(negedge clk);

    check("rst_ready",    {31'd0, req_ready}, 32'd1);
    check("rst_rsp",      {31'd0, rsp_valid}, 32'd0);
    check("rst_rd",       {31'd0, mem_rd},    32'd0);
    check("rst_wr",       {31'd0, mem_wr},    32'd0);
    check("rst_addr",     {16'd0, mem_addr},  32'd0);
    check("rst_rdata",    {16'd0, rsp_rdata}, 32'd0);
    rst = 1'b0;

    do_req(1'b1, 1'b0, 16'h1234, 16'h00A5, lat, rd);
    check("bw_lat",   lat, 32'd2);
    check("bw_rdata", {16'd0, rd}, 32'd0);
    check("bw_mem",   {24'd0, mem_arr[16'h1234]}, 32'hA5);

    do_req(1'b0, 1'b0, 16'h1234, 16'h0000, lat, rd);
    check("br_lat",   lat, 32'd3);
    check("br_rdata", {16'd0, rd}, 32'h00A5);
    check("br_addr_hold", {16'd0, mem_addr}, 32'h1234);

    do_req(1'b1, 1'b1, 16'h0100, 16'hBEEF, lat, rd);
    check("ww_lat",    lat, 32'd3);
    check("ww_mem_lo", {24'd0, mem_arr[16'h0100]}, 32'hEF);
    check("ww_mem_hi", {24'd0, mem_arr[16'h0101]}, 32'hBE);

    do_req(1'b0, 1'b1, 16'h0100, 16'h0000, lat, rd);
    check("wr_lat",   lat, 32'd4);
    check("wr_rdata", {16'd0, rd}, 32'hBEEF);
    check("wr_addr_hold", {16'd0, mem_addr}, 32'h0101);
    repeat (3) @(negedge clk);
    check("rdata_hold", {16'd0, rsp_rdata}, 32'hBEEF);

    do_req(1'b1, 1'b1, 16'hFFFF, 16'h1122, lat, rd);
    check("wrap_w_lat", lat, 32'd3);
    check("wrap_mem_ffff", {24'd0, mem_arr[16'hFFFF]}, 32'h22);
    check("wrap_mem_0000", {24'd0, mem_arr[16'h0000]}, 32'h11);

    do_req(1'b0, 1'b1, 16'hFFFF, 16'h0000, lat, rd);
    check("wrap_r_lat",   lat, 32'd4);
    check("wrap_r_rdata", {16'd0, rd}, 32'h1122);
    check("wrap_addr",    {16'd0, mem_addr}, 32'h0000);

    // Three byte reads with req_valid held high: accept every 4th cycle.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_wide  = 1'b0;
    got       = 0;
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) @(negedge clk);
      if (c % 4 == 0 && c <= 8) req_addr = b2b_addr[c / 4];
      if (c == 9) req_valid = 1'b0;
      check("b2b_ready", {31'd0, req_ready}, {31'd0, c % 4 == 0});
      check("b2b_rsp",   {31'd0, rsp_valid}, {31'd0, (c % 4 == 3)});
      if (rsp_valid && got < 3) begin
        check("b2b_rdata", {16'd0, rsp_rdata}, {16'd0, b2b_exp[got]});
        got++;
      end
    end
    check("b2b_count", got, 32'd3);

    // Wide write aborted by reset landing on the edge that would start HI.
    saved_byte = mem_arr[16'h2001];
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_wide  = 1'b1;
    req_addr  = 16'h2000;
    req_wdata = 16'h5A3C;
    check("abort_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_lo_wr",   {31'd0, mem_wr},   32'd1);
    check("abort_lo_addr", {16'd0, mem_addr}, 32'h2000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready_after", {31'd0, req_ready}, 32'd1);
    check("abort_wr_off",      {31'd0, mem_wr},    32'd0);
    check("abort_addr_clr",    {16'd0, mem_addr},  32'd0);
    check("abort_rdata_clr",   {16'd0, rsp_rdata}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      check("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
      check("abort_no_wr",  {31'd0, mem_wr},    32'd0);
      @(negedge clk);
    end
    check("abort_mem_lo", {24'd0, mem_arr[16'h2000]}, 32'h3C);
    check("abort_mem_hi", {24'd0, mem_arr[16'h2001]}, {24'd0, saved_byte});

    // Reset wins over a simultaneous request.
    saved_byte = mem_arr[16'h4000];
    rst       = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_wide  = 1'b0;
    req_addr  = 16'h4000;
    req_wdata = 16'h0077;
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 1'b0;
    check("rstpri_no_wr", {31'd0, mem_wr},    32'd0);
    check("rstpri_ready", {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rstpri_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    check("rstpri_mem", {24'd0, mem_arr[16'h4000]}, {24'd0, saved_byte});

    do_req(1'b0, 1'b0, 16'h2000, 16'h0000, lat, rd);
    check("post_br_lat",   lat, 32'd3);
    check("post_br_rdata", {16'd0, rd}, 32'h003C);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
